// File: rtl/mult_pkg.sv
// Shared encodings and elaboration-time helpers for the pipelined Booth multiplier / MAC.
package mult_pkg;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_MAC = 2'b01;
  localparam logic [1:0] MODE_MSU = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
    logic       clr;
  } ctrl_t;

  function automatic int unsigned booth_rows(int unsigned width);
    return width / 2 + 1;
  endfunction

  // One 3:2 level turns every full group of three rows into two.
  function automatic int unsigned csa_next(int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned csa_rows_at(int unsigned n, int unsigned lvl);
    int unsigned r = n;
    for (int unsigned i = 0; i < lvl; i++) r = csa_next(r);
    return r;
  endfunction

  function automatic int unsigned csa_levels(int unsigned n);
    int unsigned r = n;
    int unsigned l = 0;
    while (r > 2) begin
      r = csa_next(r);
      l++;
    end
    return l;
  endfunction

  // Spreads red_stages register boundaries as evenly as possible over the CSA levels.
  function automatic bit reg_after_level(int unsigned lvl, int unsigned levels,
                                         int unsigned red_stages);
    for (int unsigned k = 1; k <= red_stages; k++) begin
      if ((k * levels) / (red_stages + 1) == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial-product rows for two (WIDTH+1)-bit signed operands, each row
// pre-shifted and sign-extended to 2*WIDTH bits (arithmetic is modulo 2^(2*WIDTH)).
module booth_r4_pp_gen
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]                                 a_i,
  input  logic [WIDTH:0]                                 b_i,
  output logic [booth_rows(WIDTH)-1:0][2*WIDTH-1:0]      pp_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NRows = booth_rows(WIDTH);

  logic [WIDTH+2:0] b_win;
  logic [PW-1:0]    a_x;

  // Extra sign bit makes the operand even-length; the trailing zero is b[-1].
  assign b_win = {b_i[WIDTH], b_i, 1'b0};
  assign a_x   = {{(PW - WIDTH - 1){a_i[WIDTH]}}, a_i};

  logic [2:0]    trip;
  logic [PW-1:0] mag;
  logic          neg;

  always_comb begin
    trip = '0;
    mag  = '0;
    neg  = 1'b0;
    pp_o = '0;
    for (int unsigned i = 0; i < NRows; i++) begin
      trip = b_win[2*i +: 3];
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: mag = a_x;
        3'b011:         mag = a_x << 1;
        3'b100: begin
          mag = a_x << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_x;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      pp_o[i] = (neg ? (~mag + 1'b1) : mag) << (2 * i);
    end
  end

endmodule

// File: rtl/mult_mac_pipe.sv
// Fully pipelined radix-4 Booth multiplier / MAC with valid-ready on both sides and a
// global stall whenever the output register is held.
module mult_mac_pipe
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_multa_ns,
  input  logic               i_multb_ns,
  input  logic [WIDTH-1:0]   i_multa,
  input  logic [WIDTH-1:0]   i_multb,
  input  logic [1:0]         i_mode,
  input  logic               i_acc_clr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NRows = booth_rows(WIDTH);
  localparam int unsigned NLvl  = csa_levels(NRows);
  localparam int unsigned NRed  = PIPE_STAGES - 2;

  logic adv;

  assign adv     = !(o_valid && !i_ready);
  assign o_ready = adv;

  // Stage 1: operand / control capture.
  logic [WIDTH:0] a_d, a_q, b_d, b_q;
  ctrl_t          c1_d, c1_q;

  always_comb begin
    a_d        = {i_multa_ns & i_multa[WIDTH-1], i_multa};
    b_d        = {i_multb_ns & i_multb[WIDTH-1], i_multb};
    c1_d.valid = i_valid;
    c1_d.mode  = (i_mode == MODE_MAC || i_mode == MODE_MSU) ? i_mode : MODE_MUL;
    c1_d.clr   = i_acc_clr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c1_q <= '0;
    end else if (adv) begin
      a_q  <= a_d;
      b_q  <= b_d;
      c1_q <= c1_d;
    end
  end

  logic [NRows-1:0][PW-1:0] pp;

  booth_r4_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .a_i  (a_q),
    .b_i  (b_q),
    .pp_o (pp)
  );

  // Reduction: lvl_in[l] feeds level l, lvl_out[l] is that level after an optional register.
  logic [NRows-1:0][PW-1:0] lvl_in  [NLvl+1];
  logic [NRows-1:0][PW-1:0] lvl_out [NLvl+1];
  ctrl_t                    ctl_in  [NLvl+1];
  ctrl_t                    ctl_out [NLvl+1];

  assign lvl_in[0] = pp;
  assign ctl_in[0] = c1_q;

  for (genvar l = 0; l <= NLvl; l++) begin : g_lvl
    if (reg_after_level(l, NLvl, NRed)) begin : g_reg
      logic [NRows-1:0][PW-1:0] rows_q;
      ctrl_t                    ctl_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ctl_q <= '0;
        end else if (adv) begin
          rows_q <= lvl_in[l];
          ctl_q  <= ctl_in[l];
        end
      end

      assign lvl_out[l] = rows_q;
      assign ctl_out[l] = ctl_q;
    end else begin : g_wire
      assign lvl_out[l] = lvl_in[l];
      assign ctl_out[l] = ctl_in[l];
    end

    if (l < NLvl) begin : g_csa
      localparam int unsigned Cnt = csa_rows_at(NRows, l);
      localparam int unsigned Grp = Cnt / 3;
      localparam int unsigned Rem = Cnt % 3;

      logic [NRows-1:0][PW-1:0] nxt;

      always_comb begin
        nxt = '0;
        for (int unsigned g = 0; g < Grp; g++) begin
          nxt[2*g]   = lvl_out[l][3*g] ^ lvl_out[l][3*g+1] ^ lvl_out[l][3*g+2];
          nxt[2*g+1] = ((lvl_out[l][3*g] & lvl_out[l][3*g+1]) |
                        (lvl_out[l][3*g] & lvl_out[l][3*g+2]) |
                        (lvl_out[l][3*g+1] & lvl_out[l][3*g+2])) << 1;
        end
        for (int unsigned r = 0; r < Rem; r++) begin
          nxt[2*Grp+r] = lvl_out[l][3*Grp+r];
        end
      end

      assign lvl_in[l+1] = nxt;
      assign ctl_in[l+1] = ctl_out[l];
    end
  end

  // Final stage: carry-propagate add, then result / accumulator register.
  logic [PW-1:0] prod, acc_base, acc_n;
  logic [PW-1:0] acc_d, acc_q, res_d, res_q;
  logic          vld_d, vld_q;
  ctrl_t         cf;

  assign prod = lvl_out[NLvl][0] + lvl_out[NLvl][1];
  assign cf   = ctl_out[NLvl];

  always_comb begin
    acc_base = cf.clr ? '0 : acc_q;
    acc_n    = (cf.mode == MODE_MSU) ? acc_base - prod : acc_base + prod;
    acc_d    = acc_q;
    res_d    = res_q;
    vld_d    = vld_q;
    if (adv) begin
      vld_d = cf.valid;
      if (cf.valid) begin
        if (cf.mode == MODE_MUL) begin
          res_d = prod;
        end else begin
          acc_d = acc_n;
          res_d = acc_n;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      acc_q <= acc_d;
    end
  end

  assign o_valid  = vld_q;
  assign o_result = res_q;

endmodule

// File: tb/tb_mult_mac_pipe.sv
// Scoreboard bench for mult_mac_pipe: a 32-bit/3-stage and an 8-bit/2-stage instance.
module tb_mult_mac_pipe;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic rst;

  // 32-bit instance
  logic        valid, ready_o, ans, bns, clr, out_valid, ready_i;
  logic [31:0] ia, ib;
  logic [1:0]  mode;
  logic [63:0] res;

  mult_mac_pipe #(
    .WIDTH       (32),
    .PIPE_STAGES (3)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .o_ready    (ready_o),
    .i_multa_ns (ans),
    .i_multb_ns (bns),
    .i_multa    (ia),
    .i_multb    (ib),
    .i_mode     (mode),
    .i_acc_clr  (clr),
    .o_valid    (out_valid),
    .i_ready    (ready_i),
    .o_result   (res)
  );

  // 8-bit instance
  logic        e_valid, e_ready_o, e_ans, e_bns, e_clr, e_out_valid, e_ready_i;
  logic [7:0]  e_a, e_b;
  logic [1:0]  e_mode;
  logic [15:0] e_res;

  mult_mac_pipe #(
    .WIDTH       (8),
    .PIPE_STAGES (2)
  ) u_dut8 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (e_valid),
    .o_ready    (e_ready_o),
    .i_multa_ns (e_ans),
    .i_multb_ns (e_bns),
    .i_multa    (e_a),
    .i_multb    (e_b),
    .i_mode     (e_mode),
    .i_acc_clr  (e_clr),
    .o_valid    (e_out_valid),
    .i_ready    (e_ready_i),
    .o_result   (e_res)
  );

  typedef struct {
    logic [63:0] exp;
    int          acc_cyc;
    bit          lat;
  } sb_t;

  sb_t q32[$];
  sb_t q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance, including stall stability.
  logic [63:0] hold_res;
  bit          stalled = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (stalled) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", res, hold_res);
      end
      stalled = 1'b0;
      if (out_valid && !ready_i) begin
        chk("stall_ready", {63'd0, ready_o}, 64'd0);
        hold_res = res;
        stalled  = 1'b1;
      end
      if (out_valid && ready_i) begin
        if (q32.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected32: got %h want none", res);
        end else begin
          e = q32.pop_front();
          chk("result32", res, e.exp);
          if (e.lat) chk("latency32", 64'(cyc - e.acc_cyc), 64'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (!rst && e_out_valid && e_ready_i) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected8: got %h want none", e_res);
      end else begin
        e = q8.pop_front();
        chk("result8", {48'd0, e_res}, e.exp);
        if (e.lat) chk("latency8", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input logic [1:0] m, input logic c,
                        input logic [63:0] exp, input bit lat);
    int n = 0;
    valid = 1'b1; ia = a; ib = b; ans = sa; bns = sb; mode = m; clr = c;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL send32_timeout: got ready=0 want ready=1");
    end else begin
      q32.push_back('{exp, cyc, lat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sa,
                       input logic sb, input logic [1:0] m, input logic c,
                       input logic [15:0] exp);
    e_valid = 1'b1; e_a = a; e_b = b; e_ans = sa; e_bns = sb; e_mode = m; e_clr = c;
    @(negedge clk);
    if (!e_ready_o) begin
      total++;
      bad++;
      $display("FAIL send8_ready: got 0 want 1");
    end else begin
      q8.push_back('{{48'd0, exp}, cyc, 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? q32.size() : q8.size()) != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL drain%0d_timeout: got %0d pending want 0", which,
               (which == 0) ? q32.size() : q8.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    valid = 1'b0; ia = '0; ib = '0; ans = 1'b0; bns = 1'b0; mode = MODE_MUL; clr = 1'b0;
    ready_i = 1'b1;
    e_valid = 1'b0; e_a = '0; e_b = '0; e_ans = 1'b0; e_bns = 1'b0; e_mode = MODE_MUL;
    e_clr = 1'b0; e_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", res, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_valid8", {63'd0, e_out_valid}, 64'd0);
    chk("rst_result8", {48'd0, e_res}, 64'd0);
    @(posedge clk);
    #1;

    // Single beats: unsigned, signed, mixed, signed negative, reserved mode as MUL
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, MODE_MUL, 0, 64'hFFFFFFFE00000001, 1);
    valid = 1'b0;
    drain(0);
    send32(32'hFFFFFFFF, 32'd2, 1, 1, MODE_MUL, 0, 64'hFFFFFFFFFFFFFFFE, 1);
    valid = 1'b0;
    drain(0);
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, MODE_MUL, 0, 64'hFFFFFFFF00000001, 1);
    valid = 1'b0;
    drain(0);
    send32(32'hFFFFFFF9, 32'd6, 1, 1, MODE_MUL, 0, 64'hFFFFFFFFFFFFFFD6, 1);
    send32(32'd3, 32'd5, 0, 0, 2'b11, 1, 64'd15, 1);
    valid = 1'b0;
    drain(0);

    // Back-to-back accumulate chain
    send32(32'd3, 32'd4, 0, 0, MODE_MAC, 1, 64'd12, 1);
    send32(32'd5, 32'd6, 0, 0, MODE_MAC, 0, 64'd42, 1);
    send32(32'd2, 32'd1, 0, 0, MODE_MSU, 0, 64'd40, 1);
    send32(32'd7, 32'd7, 0, 0, MODE_MUL, 0, 64'd49, 1);
    // Invalid beat with MAC+clr on the bus must be ignored
    valid = 1'b0; ia = 32'd100; ib = 32'd100; mode = MODE_MAC; clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send32(32'd1, 32'd1, 0, 0, MODE_MAC, 0, 64'd41, 1);
    valid = 1'b0;
    drain(0);

    // Back-pressure: six beats while the sink holds off for five cycles
    ready_i = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          send32(32'(i + 1), 32'(i + 10), 0, 0, MODE_MUL, 0,
                 64'((i + 1) * (i + 10)), 0);
        end
        valid = 1'b0;
      end
    join
    drain(0);

    // Reset with two beats in flight and acc = 42
    send32(32'd6, 32'd7, 0, 0, MODE_MAC, 1, 64'd42, 0);
    valid = 1'b0;
    drain(0);
    send32(32'd9, 32'd9, 0, 0, MODE_MUL, 0, 64'd81, 0);
    send32(32'd8, 32'd8, 0, 0, MODE_MUL, 0, 64'd64, 0);
    valid = 1'b0;
    rst = 1'b1;
    q32.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("flush_result", res, 64'd0);
    @(posedge clk);
    #1;
    send32(32'd2, 32'd3, 0, 0, MODE_MAC, 0, 64'd6, 1);
    valid = 1'b0;
    drain(0);

    // Wrap-around accumulate
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, MODE_MAC, 1, 64'hFFFFFFFE00000001, 1);
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, MODE_MAC, 0, 64'hFFFFFFFC00000002, 1);
    valid = 1'b0;
    drain(0);

    // 8-bit, two-stage instance
    send8(8'hFF, 8'hFF, 0, 0, MODE_MAC, 1, 16'hFE01);
    send8(8'hFF, 8'hFF, 0, 0, MODE_MAC, 0, 16'hFC02);
    send8(8'hFF, 8'hFF, 1, 1, MODE_MUL, 0, 16'h0001);
    send8(8'h80, 8'hFF, 1, 0, MODE_MUL, 0, 16'h8080);
    e_valid = 1'b0;
    drain(1);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
